// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
// Holds the FIFO byte width, the packer FSM states and the keep-mask helper.
package fifo_pkg;

    localparam int FIFO_DW   = 8;
    localparam int MAX_BYTES = 8;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        EMIT
    } pack_state_e;

    // Lane mask with the low cnt bits set.
    function automatic logic [MAX_BYTES-1:0] keep_mask(input int cnt);
        logic [MAX_BYTES-1:0] m;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i < cnt);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_out_slot.sv
// Single-entry valid/ready holding register for a packed word.
// Ports: i_load/i_data/i_keep/i_last fill the slot; i_ready drains it;
// o_valid/o_data/o_keep/o_last present the held word downstream.
module fifo_out_slot
    import fifo_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic [K-1:0] i_keep,
    input  logic         i_last,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [K-1:0] o_keep,
    output logic         o_last
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic [K-1:0] r_keep;
    logic         r_last;

    // A load wins over a same-edge accept: transfer and reload together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains bytes from a synchronous FIFO and packs them little-endian into
// BYTES-wide words on a valid/ready port; flush emits a partial word.
// Ports: clk, rst (sync, active-high); fifo_empty/fifo_rdata/fifo_r_en to
// the FIFO; out_data/out_keep/out_last/out_valid/out_ready downstream;
// flush request, flush_done pulse, busy status.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DW,
    parameter int BYTES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    input  logic [DATA_W-1:0]       fifo_rdata,
    output logic                    fifo_r_en,
    output logic [DATA_W*BYTES-1:0] out_data,
    output logic [BYTES-1:0]        out_keep,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    busy
);

    localparam int CW = $clog2(BYTES + 1);
    localparam int OW = DATA_W * BYTES;

    pack_state_e                   r_state;
    pack_state_e                   w_state_nxt;
    logic [CW-1:0]                 r_count;
    logic                          r_inflight;
    logic                          r_flush_done;
    logic [BYTES-1:0][DATA_W-1:0]  r_lanes;
    logic [BYTES-1:0][DATA_W-1:0]  w_lanes;
    logic [CW-1:0]                 w_count_land;
    logic                          w_full;
    logic                          w_slot_free;
    logic                          w_load;
    logic                          w_last;
    logic                          w_done;
    logic [MAX_BYTES-1:0]          w_kfull;
    logic [BYTES-1:0]              w_keep;
    logic [OW-1:0]                 w_data;

    // Count including the byte landing this cycle.
    assign w_count_land = r_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_full       = (w_count_land == CW'(BYTES));
    assign w_slot_free  = !out_valid || out_ready;
    assign w_kfull      = keep_mask(int'(r_count));

    // Assembly with the landing byte merged in, so a word can complete
    // and load on the very edge its last byte arrives.
    always_comb begin
        w_lanes = r_lanes;
        for (int i = 0; i < BYTES; i++) begin
            if (r_inflight && (r_count == CW'(i))) begin
                w_lanes[i] = fifo_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:     if (flush) w_state_nxt = DRAIN;
            DRAIN:   if (!r_inflight) w_state_nxt = EMIT;
            EMIT:    if (w_done) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_last = 1'b0;
        w_done = 1'b0;
        w_keep = '1;
        unique case (r_state)
            RUN: begin
                if (w_full && w_slot_free) w_load = 1'b1;
            end
            DRAIN: ;
            EMIT: begin
                if (r_count == '0) begin
                    w_done = 1'b1;
                end else if (w_slot_free) begin
                    w_load = 1'b1;
                    w_last = 1'b1;
                    w_done = 1'b1;
                    w_keep = w_kfull[BYTES-1:0];
                end
            end
            default: ;
        endcase
    end

    // Unused lanes go out as zero.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_data[i*DATA_W +: DATA_W] = w_keep[i] ? w_lanes[i] : '0;
        end
    end

    assign fifo_r_en = !rst && (r_state == RUN) && !fifo_empty && !flush
                       && (w_count_land < CW'(BYTES));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_inflight   <= 1'b0;
            r_flush_done <= 1'b0;
            r_lanes      <= '0;
        end else begin
            r_inflight   <= fifo_r_en;
            r_flush_done <= w_done;
            r_lanes      <= w_lanes;
            r_count      <= w_load ? '0 : w_count_land;
        end
    end

    fifo_out_slot #(
        .W (OW),
        .K (BYTES)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_data),
        .i_keep  (w_keep),
        .i_last  (w_last),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_keep  (out_keep),
        .o_last  (out_last)
    );

    assign flush_done = r_flush_done;
    assign busy       = r_inflight || (r_count != '0) || out_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer with a behavioural FIFO model.
// Table of 4-byte words plus directed stall, flush and reset sequences.
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        fifo_r_en;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        flush = 1'b0;
    logic        flush_done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_rd_packer #(
        .DATA_W (8),
        .BYTES  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_r_en  (fifo_r_en),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy)
    );

    // FIFO model: data appears one cycle after the read enable.
    logic [7:0] mem [0:255];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_r_en && (wp != rp)) begin
            fifo_rdata <= mem[rp[7:0]];
            rp <= rp + 1;
        end
    end

    // Monitor, sampled on the falling edge.
    logic [31:0] gd [$];
    logic [3:0]  gk [$];
    logic        gl [$];
    logic        gf [$];
    int          uf = 0;
    int          fd_cnt = 0;
    int          stab_bad = 0;
    logic        hold = 1'b0;
    logic [36:0] hv = '0;

    always @(negedge clk) begin
        if (fifo_r_en && fifo_empty) uf++;
        if (flush_done) fd_cnt++;
        if (hold && (!out_valid || ({out_data, out_keep, out_last} != hv)))
            stab_bad++;
        hold = out_valid && !out_ready && !rst;
        hv   = {out_data, out_keep, out_last};
        if (out_valid && out_ready) begin
            gd.push_back(out_data);
            gk.push_back(out_keep);
            gl.push_back(out_last);
            gf.push_back(flush_done);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp[7:0]] = b;
        wp = wp + 1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic get_word(input string nm, input logic [31:0] ed,
                            input logic [3:0] ek, input logic el);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (gd.size() > 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk({nm, "_arrived"}, {63'd0, ok}, 64'd1);
        if (ok) begin
            chk({nm, "_data"}, {32'd0, gd.pop_front()}, {32'd0, ed});
            chk({nm, "_keep"}, {60'd0, gk.pop_front()}, {60'd0, ek});
            chk({nm, "_last"}, {63'd0, gl.pop_front()}, {63'd0, el});
            void'(gf.pop_front());
        end
    endtask

    typedef struct {
        logic [7:0]  b [4];
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        logic        exp_last;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int fd0;
        logic fdv;

        tbl[0] = '{'{8'h11, 8'h22, 8'h33, 8'h44}, 32'h44332211, 4'hF, 1'b0};
        tbl[1] = '{'{8'h00, 8'hFF, 8'h00, 8'hFF}, 32'hFF00FF00, 4'hF, 1'b0};
        tbl[2] = '{'{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 32'hEFBEADDE, 4'hF, 1'b0};
        tbl[3] = '{'{8'h01, 8'h02, 8'h04, 8'h80}, 32'h80040201, 4'hF, 1'b0};

        rst = 1'b1;
        repeat (3) step();
        chk("rst_r_en", {63'd0, fifo_r_en}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data", {32'd0, out_data}, 64'd0);
        chk("rst_keep", {60'd0, out_keep}, 64'd0);
        chk("rst_last", {63'd0, out_last}, 64'd0);
        chk("rst_fdone", {63'd0, flush_done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < 4; j++) push(tbl[v].b[j]);
            get_word($sformatf("tbl%0d", v), tbl[v].exp_data,
                     tbl[v].exp_keep, tbl[v].exp_last);
        end

        // Backpressure: slot and assembly both fill, reads stall.
        out_ready = 1'b0;
        for (int j = 0; j < 12; j++) push(8'(j));
        repeat (20) step();
        chk("bp_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_data", {32'd0, out_data}, 64'h03020100);
        chk("bp_r_en", {63'd0, fifo_r_en}, 64'd0);
        chk("bp_consumed", 64'(rp - 16), 64'd8);
        out_ready = 1'b1;
        get_word("bp0", 32'h03020100, 4'hF, 1'b0);
        get_word("bp1", 32'h07060504, 4'hF, 1'b0);
        get_word("bp2", 32'h0B0A0908, 4'hF, 1'b0);

        // Partial flush after two bytes have landed.
        push(8'hA1);
        push(8'hB2);
        repeat (6) step();
        chk("pf_busy", {63'd0, busy}, 64'd1);
        fd0 = fd_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        fdv = 1'b0;
        for (int i = 0; i < 20 && gd.size() == 0; i++) step();
        if (gf.size() > 0) fdv = gf[0];
        get_word("pf", 32'h0000B2A1, 4'b0011, 1'b1);
        chk("pf_fdone_on_load", {63'd0, fdv}, 64'd1);
        repeat (3) step();
        chk("pf_fdone_pulses", 64'(fd_cnt - fd0), 64'd1);

        // Empty flush: only a flush_done pulse.
        fd0 = fd_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (6) step();
        chk("ef_fdone_pulses", 64'(fd_cnt - fd0), 64'd1);
        chk("ef_no_word", 64'(gd.size()), 64'd0);
        chk("ef_busy", {63'd0, busy}, 64'd0);
        for (int j = 0; j < 4; j++) push(8'hC0 + 8'(j));
        get_word("ef_run", 32'hC3C2C1C0, 4'hF, 1'b0);

        // Flush on the same edge the second byte lands.
        push(8'h55);
        push(8'h66);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        get_word("fl", 32'h00006655, 4'b0011, 1'b1);

        // Reset with three bytes assembled and one in flight.
        repeat (4) step();
        for (int j = 0; j < 4; j++) push(8'h91 + 8'(j));
        step();
        step();
        step();
        step();
        chk("mr_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_r_en", {63'd0, fifo_r_en}, 64'd0);
        chk("mr_valid", {63'd0, out_valid}, 64'd0);
        chk("mr_data", {32'd0, out_data}, 64'd0);
        chk("mr_keep", {60'd0, out_keep}, 64'd0);
        chk("mr_last", {63'd0, out_last}, 64'd0);
        chk("mr_fdone", {63'd0, flush_done}, 64'd0);
        chk("mr_busy0", {63'd0, busy}, 64'd0);
        chk("mr_no_word", 64'(gd.size()), 64'd0);
        for (int j = 0; j < 4; j++) push(8'hA0 + 8'(j));
        get_word("mr_after", 32'hA3A2A1A0, 4'hF, 1'b0);

        repeat (5) step();
        chk("no_extra_words", 64'(gd.size()), 64'd0);
        chk("underflow_reads", 64'(uf), 64'd0);
        chk("hold_stable", 64'(stab_bad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the 8-bit synchronous FIFO. Drains bytes while the FIFO is not empty and packs BYTES consecutive bytes, little-endian, into one wide word.
- Presents packed words on a valid/ready output port toward the downstream datapath.
- A flush request forces out a partial word, with a byte-keep mask marking which lanes hold data.

Parameters:
- DATA_W, 8, FIFO byte width; must match the FIFO data width.
- BYTES, 4, bytes per packed word; legal range 2..8.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdata  input  DATA_W  FIFO read data; valid exactly 1 cycle after fifo_r_en.
- fifo_r_en  output  1  FIFO read enable.
- out_data  output  DATA_W*BYTES  packed word; byte 0 is the first byte read, in bits [7:0].
- out_keep  output  BYTES  lane-valid mask.
- out_last  output  1  marks the final word of a flush.
- out_valid  output  1  word available.
- out_ready  input  1  downstream accept.
- flush  input  1  single-cycle request to emit a partial word.
- flush_done  output  1  one-cycle pulse when the flush completes.
- busy  output  1  high when any byte is in flight, assembling, or in the output slot.

Behaviour:
- Reset values: fifo_r_en=0, out_valid=0, out_data=0, out_keep=0, out_last=0, flush_done=0, busy=0. Lane count=0, in-flight=0, state=RUN.
- Reset during operation: an in-flight byte is discarded and the assembly is cleared. Recovering the FIFO is the FIFO owner's responsibility.
- Read latency: fifo_r_en at cycle N means the byte is captured from fifo_rdata at the edge ending cycle N+1. At most 1 byte is in flight.
- fifo_r_en is combinational and asserts when all of the following hold:
  - state==RUN
  - !fifo_empty
  - !flush
  - count+inflight < BYTES
- The block never reads while the FIFO is empty; this is the underflow guard.
- Lane placement: a landing byte writes lane[count], then count increments.
- Word completion, count reaching BYTES:
  - If the output slot is free (!out_valid) or draining (out_valid&&out_ready), the word loads into the slot on that same edge with out_keep all-ones, and count returns to 0.
  - Otherwise the assembly holds with count==BYTES. Reads stall until the slot frees, and the word loads on the first free/draining edge.
- Throughput: max 4 bytes per 5 cycles at BYTES=4, given a non-empty FIFO and out_ready held high.
- Output handshake: once out_valid=1, out_data, out_keep and out_last stay stable until out_valid&&out_ready. A transfer and a reload on the same edge is legal.
- States:
  - RUN: normal packing. flush moves to DRAIN.
  - DRAIN: no new reads. Wait until inflight==0, then go to EMIT.
  - EMIT: handled as follows.
    - count==0: pulse flush_done and return to RUN; no word is emitted.
    - count>0: wait for the output slot to be free or draining. Then load the word with unused lanes zeroed, out_keep=(1<<count)-1 and out_last=1. Clear count, pulse flush_done on that edge, and return to RUN.
    - count==BYTES in EMIT: emit a full word with out_last=1.
- flush asserted outside RUN is ignored.
- flush and a byte landing on the same edge: the byte is kept and included in the flushed word.
- out_last is 0 on every non-flush word.

Decomposition:
- Package fifo_pkg holds:
  - FIFO_DW=8
  - typedef enum {RUN, DRAIN, EMIT} pack_state_e
  - a helper function keep_mask(count)
- One natural sub-module, fifo_out_slot: a single-entry valid/ready holding register for data, keep and last, with load and accept semantics. The packer instantiates it once.

Test Plan:
- Write 0x11,0x22,0x33,0x44 to the FIFO, out_ready=1 -> one word 0x44332211, keep=4'hF, last=0. fifo_r_en never high while empty.
- Write 12 bytes 0x00..0x0B, out_ready=0 for 20 cycles, then 1 -> 3 words 0x03020100, 0x07060504, 0x0B0A0908 in order. No byte lost. Reads stall while the slot and assembly are full.
- Write 0xA1,0xB2, wait until both land, pulse flush -> word 0x0000B2A1, keep=4'b0011, last=1, flush_done pulse on the load edge.
- Pulse flush with count=0 and no byte in flight -> no out_valid, flush_done 1 cycle later, state back to RUN.
- Pulse flush in the same cycle a byte lands (after 0x55, 0x66 arrives) -> word 0x00006655, keep=4'b0011, last=1.
- Assert rst with 3 bytes assembled and 1 in flight -> next cycle all outputs are at reset values. A subsequent full 4-byte sequence packs correctly from lane 0.
